// File: rtl/cas_player.sv
// cas_player: cassette playback engine producing CoCo-style FSK from a tape
// image held in SDRAM behind a fixed-latency read port.
//
// Ports:
//   clk       system clock (CLK_HZ)
//   reset     synchronous, active-high reset
//   play      motor relay, 1 = tape running (0 during PLAY pauses mid-bit)
//   rewind    level, while 1 the position returns to 0 and the engine idles
//   turbo     1 = half-periods halved, sampled at the start of each bit
//   tape_len  number of valid bytes in the image
//   mem_addr  byte address of the current fetch, doubles as tape position
//   mem_rd    one-cycle read strobe
//   mem_data  read data, valid RD_LAT cycles after mem_rd
//   data      FSK output: bit 0 = one TONE0 cycle, bit 1 = one TONE1 cycle
//   active    1 while the waveform is being produced
//   eot       end of tape reached
//
// state | meaning
// IDLE  | stopped, waiting for play
// FETCH | first byte read in flight, waiting RD_LAT cycles for mem_data
// PLAY  | serialising shift_reg LSB first; next byte prefetched during bit 7
// END   | position reached tape_len; held until rewind or tape_len grows

module cas_player #(
  parameter int CLK_HZ   = 50000000,
  parameter int ADDR_W   = 25,
  parameter int RD_LAT   = 2,
  parameter int TONE0_HZ = 1200,
  parameter int TONE1_HZ = 2400
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              play,
  input  logic              rewind,
  input  logic              turbo,
  input  logic [ADDR_W-1:0] tape_len,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [7:0]        mem_data,
  output logic              data,
  output logic              active,
  output logic              eot
);

  localparam int H0   = CLK_HZ / (2 * TONE0_HZ);
  localparam int H1   = CLK_HZ / (2 * TONE1_HZ);
  localparam int HMAX = (H0 > H1) ? H0 : H1;
  localparam int CW   = (HMAX < 2) ? 1 : $clog2(HMAX + 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLAY, END} state_t;

  // Half-period length for one bit; never 0 so the counter reload is safe
  // even when turbo halves a 1-cycle half.
  function automatic logic [CW-1:0] half_len(input logic b, input logic t);
    logic [CW-1:0] h;
    h = b ? CW'(H1) : CW'(H0);
    if (t) h = h >> 1;
    if (h == '0) h = CW'(1);
    return h;
  endfunction

  state_t            state;
  logic [7:0]        shift_reg;
  logic [7:0]        next_reg;
  logic              have_next;
  logic [2:0]        bit_idx;
  logic              half;       // 0 = high half, 1 = low half
  logic [CW-1:0]     cnt;        // remaining cycles of the current half, minus one
  logic [CW-1:0]     h_cur;      // half length latched at bit start
  logic [RD_LAT-1:0] rd_sr;      // read-in-flight tracker; MSB = mem_data valid now

  logic              rd_valid;
  logic [7:0]        byte_nx;
  logic              bit_nx;
  logic [CW-1:0]     h_nx;
  logic [ADDR_W:0]   addr_inc_w;
  logic              more;

  assign rd_valid   = rd_sr[RD_LAT-1];
  assign addr_inc_w = {1'b0, mem_addr} + (ADDR_W+1)'(1);
  assign more       = addr_inc_w < {1'b0, tape_len};

  // Value of the bit that starts on this edge, and its half length. A
  // prefetch landing on the very edge the byte ends is taken straight from
  // mem_data so the boundary stays seamless.
  always_comb begin
    byte_nx = rd_valid ? mem_data : next_reg;
    bit_nx  = 1'b0;
    if (state == FETCH)       bit_nx = mem_data[0];
    else if (bit_idx == 3'd7) bit_nx = byte_nx[0];
    else                      bit_nx = shift_reg[1];
    h_nx = half_len(bit_nx, turbo);
  end

  always_ff @(posedge clk) begin
    if (reset || rewind) begin
      // rewind shares the reset clear: in-flight reads are dropped via rd_sr
      state     <= IDLE;
      mem_addr  <= '0;
      mem_rd    <= 1'b0;
      data      <= 1'b0;
      active    <= 1'b0;
      eot       <= 1'b0;
      shift_reg <= '0;
      next_reg  <= '0;
      have_next <= 1'b0;
      bit_idx   <= '0;
      half      <= 1'b0;
      cnt       <= '0;
      h_cur     <= '0;
      rd_sr     <= '0;
    end else begin
      mem_rd <= 1'b0;
      rd_sr  <= (rd_sr << 1) | RD_LAT'(mem_rd);
      if (rd_valid && state == PLAY) next_reg <= mem_data;

      case (state)
        IDLE: begin
          data   <= 1'b0;
          active <= 1'b0;
          if (play) begin
            if (mem_addr < tape_len) begin
              state  <= FETCH;
              mem_rd <= 1'b1;
            end else begin
              state <= END;
              eot   <= 1'b1;
            end
          end
        end

        FETCH: begin
          if (rd_valid) begin
            shift_reg <= mem_data;
            bit_idx   <= '0;
            half      <= 1'b0;
            h_cur     <= h_nx;
            state     <= PLAY;
            if (play) begin
              cnt    <= h_nx - 1'b1;
              data   <= 1'b1;
              active <= 1'b1;
            end else begin
              // entering paused: one extra count so the resume edge
              // yields a full high half
              cnt <= h_nx;
            end
          end
        end

        PLAY: begin
          if (!play) begin
            data   <= 1'b0;
            active <= 1'b0;
          end else begin
            active <= 1'b1;
            if (cnt != '0) begin
              cnt  <= cnt - 1'b1;
              data <= ~half;
            end else if (!half) begin
              half <= 1'b1;
              cnt  <= h_cur - 1'b1;
              data <= 1'b0;
            end else if (bit_idx != 3'd7) begin
              shift_reg <= shift_reg >> 1;
              bit_idx   <= bit_idx + 1'b1;
              half      <= 1'b0;
              h_cur     <= h_nx;
              cnt       <= h_nx - 1'b1;
              data      <= 1'b1;
              if (bit_idx == 3'd6) begin
                mem_addr  <= addr_inc_w[ADDR_W-1:0];
                have_next <= more;
                mem_rd    <= more;
              end
            end else if (have_next) begin
              shift_reg <= byte_nx;
              bit_idx   <= '0;
              half      <= 1'b0;
              h_cur     <= h_nx;
              cnt       <= h_nx - 1'b1;
              data      <= 1'b1;
              have_next <= 1'b0;
            end else begin
              state  <= END;
              data   <= 1'b0;
              active <= 1'b0;
              eot    <= 1'b1;
            end
          end
        end

        END: begin
          data   <= 1'b0;
          active <= 1'b0;
          if (tape_len > mem_addr) begin
            state <= IDLE;
            eot   <= 1'b0;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
